mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DATA_W, 32, datapath/address width.
REQ-002 Parameter: REG_W, 5, destination-register index width.
REQ-003 Parameter: WB_W, 2, writeback-control width (opaque, passed through).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 alu_res_in  in  DATA_W  effective address / ALU result from EX_MEM.
REQ-007 data2_in  in  DATA_W  store data from EX_MEM.
REQ-008 pc_4_in  in  DATA_W  PC+4 from EX_MEM.
REQ-009 rd_in  in  REG_W  destination register from EX_MEM.
REQ-010 mem_ctrl_in  in  5  [4]=read, [3]=write, [2:0]=funct3.
REQ-011 wb_ctrl_in  in  WB_W  writeback control from EX_MEM.
REQ-012 dmem_req  out  1  data-memory request, held until accepted.
REQ-013 dmem_we  out  1  1=store, 0=load.
REQ-014 dmem_addr  out  DATA_W  word-aligned address {addr[31:2],2'b00}.
REQ-015 dmem_wdata  out  DATA_W  lane-replicated store data.
REQ-016 dmem_be  out  4  byte enables (stores only; 0 for loads).
REQ-017 dmem_ready  in  1  memory accepts/completes the held request this cycle.
REQ-018 dmem_rdata  in  DATA_W  load word; valid when dmem_ready=1.
REQ-019 stall_out  out  1  combinational; 1 = hold EX_MEM and upstream.
REQ-020 alu_res_out, pc_4_out, load_data_out  out  DATA_W  registered results to writeback.
REQ-021 rd_out  out  REG_W; wb_ctrl_out  out  WB_W; valid_out  out  1; misalign_out  out  1 (all registered).

Function
REQ-022 Memory op: read XOR write set; read and write both 0 = non-memory op; both 1 = illegal.
REQ-023 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-024 Fault: illegal op (REQ-022), illegal funct3, halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-025 FSM states: IDLE, BUSY; reset state IDLE.
REQ-026 IDLE, non-memory op: stall_out=0; at edge, register pass-through fields; load_data_out=0; valid_out=1; misalign_out=0.
REQ-027 IDLE, fault: no request; stall_out=0; at edge misalign_out=1, wb_ctrl_out=0, valid_out=1, pass-through fields registered.
REQ-028 IDLE, legal memory op: stall_out=1; at edge latch addr/we/be/wdata/funct3/rd/wb_ctrl/pc_4; output bubble (valid_out=0, wb_ctrl_out=0); go BUSY.
REQ-029 BUSY: dmem_req=1 with latched, stable fields; stall_out=~dmem_ready; bubble registered while dmem_ready=0.
REQ-030 BUSY and dmem_ready=1: at edge register latched fields and formatted load_data_out (0 for stores), valid_out=1; go IDLE.
REQ-031 Minimum memory-op latency is 2 cycles (one stall cycle); each dmem_ready=0 cycle adds 1.
REQ-032 Store lanes: SB be=0001<<addr[1:0], wdata={4{byte}}; SH be=0011<<{addr[1],1'b0}, wdata={2{half}}; SW be=1111.
REQ-033 Load format: select lane by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
REQ-034 dmem_req=0 in IDLE; one request per memory op; no request reissue after completion.
REQ-035 Memory-side inputs are ignored in IDLE.

Reset
REQ-036 rst_n=0 asynchronously forces IDLE, dmem_req=0, stall_out=0, and all registered outputs 0.
REQ-037 Reset during BUSY aborts the access; dmem_req drops without waiting for clk.
REQ-038 After rst_n rises, first edge behaves per IDLE rules.

Verification
REQ-039 LW addr 0x100, dmem_ready=1 in first BUSY cycle, rdata 0xDEADBEEF -> stall 1 cycle; load_data_out=0xDEADBEEF, valid_out=1 next edge.
REQ-040 LB addr 0x103, rdata 0x80FF0000 -> load_data_out=0xFFFFFF80; LBU same -> 0x00000080.
REQ-041 SH addr 0x202, data2=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-042 LW addr 0x101 -> no dmem_req, stall_out=0, misalign_out=1, wb_ctrl_out=0.
REQ-043 LW with dmem_ready low 3 BUSY cycles -> stall_out high 4 cycles, fields stable, exactly one valid_out pulse.
REQ-044 rst_n low mid-BUSY -> dmem_req and stall_out 0 immediately; outputs 0; next LW executes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory stage of the pipeline: issues one data-memory access per load/store,
// stalls upstream until the memory completes, and formats load data for writeback.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] data2_in,
    input  logic [DATA_W-1:0] pc_4_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [4:0]        mem_ctrl_in,
    input  logic [WB_W-1:0]   wb_ctrl_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] pc_4_out,
    output logic [DATA_W-1:0] load_data_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [WB_W-1:0]   wb_ctrl_out,
    output logic              valid_out,
    output logic              misalign_out
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_reg;
    logic [DATA_W-1:0]   lat_addr_reg;
    logic [DATA_W-1:0]   lat_pc4_reg;
    logic [REG_W-1:0]    lat_rd_reg;
    logic [WB_W-1:0]     lat_wb_reg;
    logic [2:0]          lat_f3_reg;

    // Request decode
    logic       is_rd, is_wr, is_mem, non_mem, f3_ok, align_ok, mem_go, fault;
    logic [2:0] f3;

    always_comb begin
        is_rd   = mem_ctrl_in[4];
        is_wr   = mem_ctrl_in[3];
        f3      = mem_ctrl_in[2:0];
        is_mem  = is_rd ^ is_wr;
        non_mem = ~is_rd & ~is_wr;
        f3_ok   = 1'b0;
        if (is_rd)
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        else if (is_wr)
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        case (f3[1:0])
            2'b01:   align_ok = ~alu_res_in[0];
            2'b10:   align_ok = (alu_res_in[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        mem_go = is_mem & f3_ok & align_ok;
        fault  = ~non_mem & ~mem_go;
    end

    // Store lane placement
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata;

    always_comb begin
        case (f3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << alu_res_in[1:0];
                st_wdata = {4{data2_in[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {alu_res_in[1], 1'b0};
                st_wdata = {2{data2_in[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = data2_in;
            end
        endcase
    end

    // Load lane selection and extension
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_fmt;

    always_comb begin
        case (lat_addr_reg[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = lat_addr_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_f3_reg)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'b0, ld_byte};
            3'b101:  ld_fmt = {16'b0, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    assign dmem_addr = {lat_addr_reg[DATA_W-1:2], 2'b00};

    // Gated by rst_n so the stall drops the instant reset asserts.
    assign stall_out = rst_n & ((state_reg == IDLE) ? mem_go : ~dmem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lat_addr_reg  <= '0;
            lat_pc4_reg   <= '0;
            lat_rd_reg    <= '0;
            lat_wb_reg    <= '0;
            lat_f3_reg    <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            alu_res_out   <= '0;
            pc_4_out      <= '0;
            load_data_out <= '0;
            rd_out        <= '0;
            wb_ctrl_out   <= '0;
            valid_out     <= 1'b0;
            misalign_out  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_go) begin
                        lat_addr_reg <= alu_res_in;
                        lat_pc4_reg  <= pc_4_in;
                        lat_rd_reg   <= rd_in;
                        lat_wb_reg   <= wb_ctrl_in;
                        lat_f3_reg   <= f3;
                        dmem_req     <= 1'b1;
                        dmem_we      <= is_wr;
                        dmem_wdata   <= st_wdata;
                        dmem_be      <= is_wr ? st_be : 4'b0000;
                        valid_out    <= 1'b0;
                        wb_ctrl_out  <= '0;
                        misalign_out <= 1'b0;
                        state_reg    <= BUSY;
                    end else begin
                        alu_res_out   <= alu_res_in;
                        pc_4_out      <= pc_4_in;
                        rd_out        <= rd_in;
                        load_data_out <= '0;
                        valid_out     <= 1'b1;
                        misalign_out  <= fault;
                        wb_ctrl_out   <= fault ? '0 : wb_ctrl_in;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        alu_res_out   <= lat_addr_reg;
                        pc_4_out      <= lat_pc4_reg;
                        rd_out        <= lat_rd_reg;
                        wb_ctrl_out   <= lat_wb_reg;
                        load_data_out <= dmem_we ? '0 : ld_fmt;
                        valid_out     <= 1'b1;
                        misalign_out  <= 1'b0;
                        dmem_req      <= 1'b0;
                        state_reg     <= IDLE;
                    end else begin
                        valid_out   <= 1'b0;
                        wb_ctrl_out <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, faults, wait states and reset abort.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_res_in, data2_in, pc_4_in;
    logic [4:0]  rd_in;
    logic [4:0]  mem_ctrl_in;
    logic [1:0]  wb_ctrl_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic [31:0] alu_res_out, pc_4_out, load_data_out;
    logic [4:0]  rd_out;
    logic [1:0]  wb_ctrl_out;
    logic        valid_out, misalign_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .REG_W(5), .WB_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_res_in(alu_res_in), .data2_in(data2_in), .pc_4_in(pc_4_in),
        .rd_in(rd_in), .mem_ctrl_in(mem_ctrl_in), .wb_ctrl_in(wb_ctrl_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out),
        .alu_res_out(alu_res_out), .pc_4_out(pc_4_out), .load_data_out(load_data_out),
        .rd_out(rd_out), .wb_ctrl_out(wb_ctrl_out),
        .valid_out(valid_out), .misalign_out(misalign_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at posedge+1; returns at posedge+1.
    task automatic mem_op(input string name, input logic [4:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] d2, input logic [4:0] rd, input logic [1:0] wb,
                          input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_load, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic exp_we);
        int stalls = 0;
        mem_ctrl_in = ctrl; alu_res_in = addr; data2_in = d2; rd_in = rd;
        wb_ctrl_in = wb; pc_4_in = addr + 32'h1000; dmem_ready = 1'b0;
        @(negedge clk);
        check({name, ".stall0"}, 32'(stall_out), 32'd1);
        check({name, ".noreq0"}, 32'(dmem_req), 32'd0);
        if (stall_out) stalls++;
        @(posedge clk); #1;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check({name, ".wreq"}, 32'(dmem_req), 32'd1);
            check({name, ".waddr"}, dmem_addr, {addr[31:2], 2'b00});
            check({name, ".wvalid"}, 32'(valid_out), 32'd0);
            if (stall_out) stalls++;
            @(posedge clk); #1;
        end
        dmem_ready = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        check({name, ".req"}, 32'(dmem_req), 32'd1);
        check({name, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({name, ".be"}, 32'(dmem_be), 32'(exp_be));
        check({name, ".wdata"}, dmem_wdata, exp_wdata);
        check({name, ".we"}, 32'(dmem_we), 32'(exp_we));
        check({name, ".bubble"}, 32'(valid_out), 32'd0);
        check({name, ".stall_rdy"}, 32'(stall_out), 32'd0);
        check({name, ".nstall"}, 32'(stalls), 32'(waits + 1));
        @(posedge clk); #1;
        dmem_ready = 1'b0; mem_ctrl_in = 5'b0;
        @(negedge clk);
        check({name, ".valid"}, 32'(valid_out), 32'd1);
        check({name, ".load"}, load_data_out, exp_load);
        check({name, ".rd"}, 32'(rd_out), 32'(rd));
        check({name, ".wb"}, 32'(wb_ctrl_out), 32'(wb));
        check({name, ".alu"}, alu_res_out, addr);
        check({name, ".pc4"}, pc_4_out, addr + 32'h1000);
        check({name, ".reqdrop"}, 32'(dmem_req), 32'd0);
        $display("op %s addr=%h waits=%0d load=%h", name, addr, waits, load_data_out);
        @(posedge clk); #1;
        check({name, ".noreissue"}, 32'(dmem_req), 32'd0);
    endtask

    task automatic fault_op(input string name, input logic [4:0] ctrl, input logic [31:0] addr,
                            input logic [4:0] rd);
        mem_ctrl_in = ctrl; alu_res_in = addr; rd_in = rd; wb_ctrl_in = 2'b11;
        dmem_ready = 1'b1;
        @(negedge clk);
        check({name, ".stall"}, 32'(stall_out), 32'd0);
        check({name, ".req"}, 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        mem_ctrl_in = 5'b0; dmem_ready = 1'b0;
        @(negedge clk);
        check({name, ".mis"}, 32'(misalign_out), 32'd1);
        check({name, ".wb"}, 32'(wb_ctrl_out), 32'd0);
        check({name, ".valid"}, 32'(valid_out), 32'd1);
        check({name, ".rd"}, 32'(rd_out), 32'(rd));
        check({name, ".req2"}, 32'(dmem_req), 32'd0);
        $display("op %s addr=%h misalign=%0b", name, addr, misalign_out);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; alu_res_in = '0; data2_in = '0; pc_4_in = '0; rd_in = '0;
        mem_ctrl_in = '0; wb_ctrl_in = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        #1;
        check("rst.req", 32'(dmem_req), 32'd0);
        check("rst.stall", 32'(stall_out), 32'd0);
        check("rst.valid", 32'(valid_out), 32'd0);
        check("rst.load", load_data_out, 32'd0);
        $display("op reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Non-memory op, with memory-side inputs toggled to show they are ignored
        alu_res_in = 32'h55; pc_4_in = 32'h1004; rd_in = 5'd7; wb_ctrl_in = 2'b10;
        dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("alu.stall", 32'(stall_out), 32'd0);
        check("alu.req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        check("alu.valid", 32'(valid_out), 32'd1);
        check("alu.res", alu_res_out, 32'h55);
        check("alu.pc4", pc_4_out, 32'h1004);
        check("alu.wb", 32'(wb_ctrl_out), 32'd2);
        check("alu.load", load_data_out, 32'd0);
        check("alu.mis", 32'(misalign_out), 32'd0);
        $display("op alu res=%h", alu_res_out);
        @(posedge clk); #1;

        mem_op("lw",  5'b10010, 32'h100, 32'h0, 5'd3, 2'b01, 0, 32'hDEADBEEF,
               32'hDEADBEEF, 4'b0000, 32'h0, 1'b0);
        mem_op("lb",  5'b10000, 32'h103, 32'h0, 5'd4, 2'b01, 0, 32'h80FF0000,
               32'hFFFFFF80, 4'b0000, 32'h0, 1'b0);
        mem_op("lbu", 5'b10100, 32'h103, 32'h0, 5'd5, 2'b01, 0, 32'h80FF0000,
               32'h00000080, 4'b0000, 32'h0, 1'b0);
        mem_op("lh",  5'b10001, 32'h102, 32'h0, 5'd6, 2'b01, 1, 32'h8001_1234,
               32'hFFFF8001, 4'b0000, 32'h0, 1'b0);
        mem_op("lhu", 5'b10101, 32'h100, 32'h0, 5'd6, 2'b01, 0, 32'h8001_F234,
               32'h0000F234, 4'b0000, 32'h0, 1'b0);
        mem_op("sh",  5'b01001, 32'h202, 32'h1234ABCD, 5'd0, 2'b00, 0, 32'h0,
               32'h0, 4'b1100, 32'hABCDABCD, 1'b1);
        mem_op("sb",  5'b01000, 32'h201, 32'h000000EF, 5'd0, 2'b00, 0, 32'hFFFF_FFFF,
               32'h0, 4'b0010, 32'hEFEFEFEF, 1'b1);
        mem_op("sw",  5'b01010, 32'h300, 32'hCAFEF00D, 5'd0, 2'b00, 2, 32'h0,
               32'h0, 4'b1111, 32'hCAFEF00D, 1'b1);
        mem_op("lw_wait3", 5'b10010, 32'h104, 32'h0, 5'd9, 2'b11, 3, 32'h0BADF00D,
               32'h0BADF00D, 4'b0000, 32'h0, 1'b0);

        fault_op("lw_mis",  5'b10010, 32'h101, 5'd10);
        fault_op("lh_mis",  5'b10001, 32'h103, 5'd11);
        fault_op("ld_f3",   5'b10011, 32'h100, 5'd12);
        fault_op("st_f3",   5'b01100, 32'h100, 5'd13);
        fault_op("rw_both", 5'b11010, 32'h100, 5'd14);

        // Reset while BUSY aborts the access
        mem_ctrl_in = 5'b10010; alu_res_in = 32'h400; rd_in = 5'd2; wb_ctrl_in = 2'b01;
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort.busyreq", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort.req", 32'(dmem_req), 32'd0);
        check("abort.stall", 32'(stall_out), 32'd0);
        check("abort.alu", alu_res_out, 32'd0);
        check("abort.rd", 32'(rd_out), 32'd0);
        $display("op reset_mid_busy");
        mem_ctrl_in = 5'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_op("lw_after_rst", 5'b10010, 32'h108, 32'h0, 5'd8, 2'b01, 0, 32'h12345678,
               32'h12345678, 4'b0000, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
